uart_apb_initiator: RTL and testbench



---
 rtl/uart_apb_pkg.sv | 20 ++
 rtl/apb_wait_timer.sv | 33 +++
 rtl/uart_apb_initiator.sv | 97 +++++++++
 tb/tb_uart_apb_initiator.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART bridge APB initiator: FSM states, register map
// and enable-register bit positions.
package uart_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_init_state_t;

    localparam logic [4:0] ADDR_ENABLE  = 5'h00;
    localparam logic [4:0] ADDR_CONTROL = 5'h04;
    localparam logic [4:0] ADDR_STATUS  = 5'h08;
    localparam logic [4:0] ADDR_DATA    = 5'h0C;

    localparam int TX_EN = 0;
    localparam int RX_EN = 1;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating count of ACCESS cycles spent without PREADY; flags the cycle in which
// the TIMEOUT-th wait cycle is being sampled.
module apb_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // count_reg holds the number of earlier wait cycles, so the current low
    // PREADY is the TIMEOUT-th one when the count has reached TIMEOUT-1.
    assign expired = (count_reg >= LAST);

endmodule

// File: rtl/uart_apb_initiator.sv
// APB requester driving the UART bridge slave port from a valid/ready command
// interface, with a PREADY wait-state timeout and one response pulse per command.
module uart_apb_initiator
    import uart_apb_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    apb_init_state_t state_reg, state_next;
    logic            req_ready_reg;
    logic            timer_clear;
    logic            timer_enable;
    logic            timer_expired;

    assign timer_clear  = (state_reg == ST_SETUP);
    assign timer_enable = (state_reg == ST_ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (req_valid) state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: if (PREADY || timer_expired) state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b0;
            PWRITE        <= 1'b0;
            PADDR         <= '0;
            PWDATA        <= '0;
            rsp_rdata     <= '0;
            rsp_error     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            // Registered so ready stays low while reset is held and rises one
            // cycle after release.
            req_ready_reg <= (state_next == ST_IDLE);
            if ((state_reg == ST_IDLE) && req_valid) begin
                PWRITE <= req_write;
                PADDR  <= req_addr;
                PWDATA <= req_wdata;
            end
            if (state_reg == ST_ACCESS) begin
                if (PREADY) begin
                    rsp_rdata <= PWRITE ? '0 : PRDATA;
                    rsp_error <= 1'b0;
                end else if (timer_expired) begin
                    rsp_rdata <= '0;
                    rsp_error <= 1'b1;
                end
            end
        end
    end

    assign req_ready = req_ready_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign PSEL      = (state_reg == ST_SETUP) || (state_reg == ST_ACCESS);
    assign PENABLE   = (state_reg == ST_ACCESS);
    assign rsp_valid = (state_reg == ST_RESP);

endmodule

// File: tb/tb_uart_apb_initiator.sv
// Self-checking bench for uart_apb_initiator: directed and random commands against
// a latency/response model derived from wait-state counts and TIMEOUT.
module tb_uart_apb_initiator;
    import uart_apb_pkg::*;

    localparam int TO = 4;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    int errors = 0;
    int checks = 0;

    // Behavioural slave: PREADY rises in ACCESS cycle slv_wait+1; noise elsewhere.
    int          slv_wait = 0;
    logic [31:0] slv_data = '0;
    int          acc_k = 0;

    uart_apb_initiator #(
        .ADDR_W  (5),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .busy      (busy),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            acc_k  = acc_k + 1;
            PREADY = (acc_k == slv_wait + 1);
            PRDATA = (acc_k == slv_wait + 1) ? slv_data : $urandom;
        end else begin
            acc_k  = 0;
            PREADY = 1'($urandom_range(0, 1));
            PRDATA = $urandom;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic w, input logic [4:0] a, input logic [31:0] d,
                           input int wt, input logic [31:0] sd);
        int          lat;
        int          exp_lat;
        int          guard;
        logic        exp_err;
        logic [31:0] exp_rd;
        bit          got;
        exp_err = (wt >= TO);
        exp_lat = exp_err ? (2 + TO) : (3 + wt);
        exp_rd  = (exp_err || w) ? 32'h0 : sd;
        slv_wait = wt;
        slv_data = sd;
        @(posedge PCLK); #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        guard = 0;
        @(negedge PCLK);
        while (!req_ready && guard < 20) begin
            @(negedge PCLK);
            guard++;
        end
        check("accept", req_ready, 1);
        @(posedge PCLK); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 5'($urandom);
        req_wdata = $urandom;
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(negedge PCLK);
            lat++;
            if (lat == 1) begin
                check("setup_psel", PSEL, 1);
                check("setup_penable", PENABLE, 0);
            end
            if (PSEL) begin
                check("paddr_hold", PADDR, a);
                check("pwrite_hold", PWRITE, w);
                if (w) check("pwdata_hold", PWDATA, d);
            end
            if (rsp_valid) got = 1;
        end
        check("rsp_seen", got, 1);
        check("latency", lat, exp_lat);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_error", rsp_error, exp_err);
        check("resp_psel", PSEL, 0);
        check("resp_busy", busy, 1);
        @(negedge PCLK);
        check("rsp_pulse", rsp_valid, 0);
        check("rdata_hold", rsp_rdata, exp_rd);
        check("error_hold", rsp_error, exp_err);
        check("idle_ready", req_ready, 1);
        check("idle_busy", busy, 0);
        $display("txn %s addr=0x%02h wdata=0x%08h wait=%0d lat=%0d err=%0b rdata=0x%08h",
                 w ? "WR" : "RD", a, d, wt, lat, rsp_error, rsp_rdata);
    endtask

    initial begin
        logic [4:0]  addr_tab [4];
        logic [4:0]  bb_a [3];
        logic [31:0] bb_d [3];
        int          rsp_t [3];
        int          cyc;
        int          nrsp;
        int          nset;
        int          issue;
        int          seen;

        addr_tab[0] = ADDR_ENABLE;
        addr_tab[1] = ADDR_CONTROL;
        addr_tab[2] = ADDR_STATUS;
        addr_tab[3] = ADDR_DATA;

        // Power-on reset
        PRESETn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        #12;
        check("rst_ready", req_ready, 0);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_error", rsp_error, 0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("rel_ready_before_edge", req_ready, 0);
        @(negedge PCLK);
        check("rel_ready_after_edge", req_ready, 1);
        $display("txn RESET power-on ready=%0b", req_ready);

        // Directed cases
        run_cmd(1'b1, ADDR_ENABLE, (32'd1 << TX_EN) | (32'd1 << RX_EN), 0, 32'hDEAD_BEEF);
        run_cmd(1'b0, ADDR_CONTROL, 32'h0, 1, 32'h0000_000D);
        run_cmd(1'b0, ADDR_DATA, 32'h0, 100, 32'h1234_5678);
        run_cmd(1'b0, ADDR_DATA, 32'h0, TO - 1, 32'h0000_00A5);

        // Reset in the middle of ACCESS
        slv_wait = 100;
        @(posedge PCLK); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = ADDR_DATA;
        @(negedge PCLK);
        check("mid_accept", req_ready, 1);
        @(posedge PCLK); #1;
        req_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        check("mid_access_psel", PSEL, 1);
        check("mid_access_penable", PENABLE, 1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("mid_rst_psel", PSEL, 0);
        check("mid_rst_penable", PENABLE, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_busy", busy, 0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("mid_rel_ready0", req_ready, 0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            if (i == 0) check("mid_rel_ready1", req_ready, 1);
            if (rsp_valid) seen++;
        end
        check("mid_no_response", seen, 0);
        $display("txn RESET mid-access responses=%0d", seen);

        // Back-to-back writes with req_valid held high
        bb_a[0] = ADDR_ENABLE;  bb_d[0] = 32'h0000_0003;
        bb_a[1] = ADDR_CONTROL; bb_d[1] = 32'h0000_0005;
        bb_a[2] = ADDR_DATA;    bb_d[2] = 32'h0000_0041;
        rsp_t[0] = 0; rsp_t[1] = 0; rsp_t[2] = 0;
        slv_wait = 0;
        @(posedge PCLK); #1;
        issue = 0; nrsp = 0; nset = 0; cyc = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = bb_a[0]; req_wdata = bb_d[0];
        while (cyc < 30) begin
            @(negedge PCLK);
            cyc++;
            check("bb_ready_vs_busy", req_ready && busy, 0);
            if (PSEL && !PENABLE && nset < 3) begin
                check("bb_paddr", PADDR, bb_a[nset]);
                check("bb_pwdata", PWDATA, bb_d[nset]);
                nset++;
            end
            if (rsp_valid && nrsp < 3) begin
                rsp_t[nrsp] = cyc;
                check("bb_rsp_error", rsp_error, 0);
                check("bb_rsp_rdata", rsp_rdata, 0);
                $display("txn BB rsp=%0d cycle=%0d", nrsp, cyc);
                nrsp++;
            end
            if (req_valid && req_ready) begin
                issue++;
                @(posedge PCLK); #1;
                if (issue < 3) begin
                    req_addr  = bb_a[issue];
                    req_wdata = bb_d[issue];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        check("bb_rsp_count", nrsp, 3);
        check("bb_setup_count", nset, 3);
        check("bb_gap1", rsp_t[1] - rsp_t[0], 4);
        check("bb_gap2", rsp_t[2] - rsp_t[1], 4);

        // Random commands
        for (int i = 0; i < 24; i++) begin
            run_cmd(1'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 3)], $urandom,
                    int'($urandom_range(0, TO + 1)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
